// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU pipeline: address width, opcode
// length flag position and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W   = 8;
    localparam int LONG_BIT = 7;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HOLD      = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous active-low reset, redirect load with priority
// over the modulo-2^ADDR_W increment.
module pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads 1- or 2-byte instructions at the PC and
// hands them to decode over a valid/ready handshake; execute may redirect.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                  ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  LONG_BIT = cpu_pkg::LONG_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target
);

    fetch_state_e      state_q, state_d;
    logic              valid_q, valid_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        operand_q, operand_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    // Each fetch state consumes exactly one byte; HOLD consumes none.
    assign pc_inc = (state_q != HOLD);

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (pc_inc),
        .load_i   (pc_load),
        .target_i (pc_target),
        .pc_o     (pc)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ipc_d     = ipc_q;
        if (pc_load) begin
            // Redirect drops any partial or held instruction.
            state_d = FETCH_OP;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                FETCH_OP: begin
                    opcode_d = mem_rdata;
                    ipc_d    = pc;
                    if (mem_rdata[LONG_BIT]) begin
                        state_d = FETCH_IMM;
                    end else begin
                        operand_d = 8'h00;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                    end
                end
                FETCH_IMM: begin
                    operand_d = mem_rdata;
                    valid_d   = 1'b1;
                    state_d   = HOLD;
                end
                HOLD: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        state_d = FETCH_OP;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = FETCH_OP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH_OP;
            valid_q   <= 1'b0;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            ipc_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ipc_q     <= ipc_d;
        end
    end

    assign mem_addr      = pc;
    assign mem_we        = 1'b0;
    assign instr_valid   = valid_q;
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign instr_pc      = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected instructions,
// a negedge monitor pops and compares every accepted handshake.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic       pc_load;
    logic [7:0] pc_target;

    logic [7:0]  mem [256];
    logic [23:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_pc      (instr_pc),
        .pc_load       (pc_load),
        .pc_target     (pc_target)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the oldest expected instruction.
    always @(negedge clk) begin
        logic [23:0] e;
        check("mem_we", {31'd0, mem_we}, 32'd0);
        if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got %h/%h@%h expected none",
                         instr_opcode, instr_operand, instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("instr", {8'd0, instr_opcode, instr_operand, instr_pc}, {8'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[8'h00] = 8'h12;
        mem[8'h01] = 8'hA3; mem[8'h02] = 8'h7E;
        mem[8'h03] = 8'h05; mem[8'h04] = 8'h06;
        mem[8'h10] = 8'hC4; mem[8'h11] = 8'h99;
        mem[8'h40] = 8'h2B;
        mem[8'hFF] = 8'h81;
        rst_n = 1'b0; instr_ready = 1'b1; pc_load = 1'b0; pc_target = 8'h00;

        // Reset state
        tick(); tick();
        check("rst_valid",   {31'd0, instr_valid}, 32'd0);
        check("rst_opcode",  {24'd0, instr_opcode}, 32'h00);
        check("rst_operand", {24'd0, instr_operand}, 32'h00);
        check("rst_ipc",     {24'd0, instr_pc}, 32'h00);
        check("rst_addr",    {24'd0, mem_addr}, 32'h00);
        rst_n = 1'b1;

        // Short instruction at 00: valid one edge later
        exp_q.push_back({8'h12, 8'h00, 8'h00});
        tick();
        check("short_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        check("short_next_addr", {24'd0, mem_addr}, 32'h01);

        // Long instruction at 01
        exp_q.push_back({8'hA3, 8'h7E, 8'h01});
        tick();
        check("long_mid_valid", {31'd0, instr_valid}, 32'd0);
        check("long_mid_addr",  {24'd0, mem_addr}, 32'h02);
        tick();
        check("long_valid", {31'd0, instr_valid}, 32'd1);
        check("long_next_addr", {24'd0, mem_addr}, 32'h03);
        tick();

        // Backpressure on short instruction at 03
        instr_ready = 1'b0;
        exp_q.push_back({8'h05, 8'h00, 8'h03});
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",  {31'd0, instr_valid}, 32'd1);
            check("bp_opcode", {24'd0, instr_opcode}, 32'h05);
            check("bp_ipc",    {24'd0, instr_pc}, 32'h03);
            check("bp_addr",   {24'd0, mem_addr}, 32'h04);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, instr_valid}, 32'd0);
        check("bp_release_addr",  {24'd0, mem_addr}, 32'h04);

        // Redirect to 10, then redirect to 40 during FETCH_IMM of C4
        pc_load = 1'b1; pc_target = 8'h10;
        tick();
        pc_load = 1'b0;
        check("redir1_valid", {31'd0, instr_valid}, 32'd0);
        check("redir1_addr",  {24'd0, mem_addr}, 32'h10);
        tick();
        check("imm_addr", {24'd0, mem_addr}, 32'h11);
        pc_load = 1'b1; pc_target = 8'h40;
        tick();
        pc_load = 1'b0;
        check("redir2_valid", {31'd0, instr_valid}, 32'd0);
        check("redir2_addr",  {24'd0, mem_addr}, 32'h40);
        exp_q.push_back({8'h2B, 8'h00, 8'h40});
        tick();
        check("redir2_instr_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        check("redir2_next_addr", {24'd0, mem_addr}, 32'h41);

        // Wrap-around: long opcode at FF takes operand from 00
        mem[8'h00] = 8'h55;
        pc_load = 1'b1; pc_target = 8'hFF;
        tick();
        pc_load = 1'b0;
        check("wrap_addr", {24'd0, mem_addr}, 32'hFF);
        exp_q.push_back({8'h81, 8'h55, 8'hFF});
        tick();
        check("wrap_imm_addr", {24'd0, mem_addr}, 32'h00);
        tick();
        check("wrap_valid", {31'd0, instr_valid}, 32'd1);
        check("wrap_next_addr", {24'd0, mem_addr}, 32'h01);
        tick();

        // Reset while in HOLD, with a simultaneous redirect (reset wins)
        instr_ready = 1'b0;
        tick(); tick();
        check("hold_before_rst", {31'd0, instr_valid}, 32'd1);
        rst_n = 1'b0; pc_load = 1'b1; pc_target = 8'h77;
        tick();
        check("mid_rst_valid",   {31'd0, instr_valid}, 32'd0);
        check("mid_rst_opcode",  {24'd0, instr_opcode}, 32'h00);
        check("mid_rst_operand", {24'd0, instr_operand}, 32'h00);
        check("mid_rst_ipc",     {24'd0, instr_pc}, 32'h00);
        check("mid_rst_addr",    {24'd0, mem_addr}, 32'h00);
        rst_n = 1'b1; pc_load = 1'b0; instr_ready = 1'b1;
        exp_q.push_back({8'h55, 8'h00, 8'h00});
        tick();
        check("post_rst_valid", {31'd0, instr_valid}, 32'd1);
        tick(); tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
